// File: rtl/depth_pkg.sv
// Shared types for the depth test unit: OpenGL depth functions and control states.
package depth_pkg;

    typedef enum logic [2:0] {
        GL_NEVER    = 3'd0,
        GL_LESS     = 3'd1,
        GL_LEQUAL   = 3'd2,
        GL_GREATER  = 3'd3,
        GL_GEQUAL   = 3'd4,
        GL_EQUAL    = 3'd5,
        GL_NOTEQUAL = 3'd6,
        GL_ALWAYS   = 3'd7
    } depth_func_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } dtu_state_t;

endpackage

// File: rtl/depth_ram.sv
// Depth buffer storage: one synchronous read port, one write port.
// A read and write to the same word in one cycle returns the old contents.
module depth_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Write and registered read share the edge, so a colliding read sees pre-write data.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/depth_test_unit.sv
// Two-stage pipelined depth test with write-back forwarding and a sequential
// full-buffer clear. Stage A reads the stored depth, stage B compares and writes.
module depth_test_unit
    import depth_pkg::*;
#(
    parameter int                Z_SIZE       = 16,
    parameter int                X_RES        = 64,
    parameter int                Y_RES        = 64,
    parameter int                X_PIXEL_SIZE = $clog2(X_RES),
    parameter int                Y_PIXEL_SIZE = $clog2(Y_RES),
    parameter logic [Z_SIZE-1:0] CLEAR_VALUE  = {Z_SIZE{1'b1}}
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    frag_valid_i,
    output logic                    frag_ready_o,
    input  logic [X_PIXEL_SIZE-1:0] frag_x_i,
    input  logic [Y_PIXEL_SIZE-1:0] frag_y_i,
    input  logic [Z_SIZE-1:0]       frag_z_i,
    input  depth_func_t             depth_func_i,
    input  logic                    depth_write_en_i,
    input  logic                    test_enable_i,
    input  logic                    clear_i,
    output logic                    clear_busy_o,
    output logic                    clear_done_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [X_PIXEL_SIZE-1:0] out_x_o,
    output logic [Y_PIXEL_SIZE-1:0] out_y_o,
    output logic [Z_SIZE-1:0]       out_z_o,
    output logic                    out_pass_o
);

    localparam int                DEPTH     = X_RES * Y_RES;
    localparam int                ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_PIXEL_SIZE-1:0] x,
                                                   input logic [Y_PIXEL_SIZE-1:0] y);
        return ADDR_W'(int'(y) * X_RES + int'(x));
    endfunction

    // Unsigned compare of the incoming fragment depth against the stored depth.
    function automatic logic depth_cmp(input depth_func_t f,
                                       input logic [Z_SIZE-1:0] z,
                                       input logic [Z_SIZE-1:0] s);
        logic r;
        case (f)
            GL_NEVER:    r = 1'b0;
            GL_LESS:     r = (z <  s);
            GL_LEQUAL:   r = (z <= s);
            GL_GREATER:  r = (z >  s);
            GL_GEQUAL:   r = (z >= s);
            GL_EQUAL:    r = (z == s);
            GL_NOTEQUAL: r = (z != s);
            GL_ALWAYS:   r = 1'b1;
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

    dtu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic                    vld_p0_q;
    logic [X_PIXEL_SIZE-1:0] x_p0_q;
    logic [Y_PIXEL_SIZE-1:0] y_p0_q;
    logic [Z_SIZE-1:0]       z_p0_q;
    depth_func_t             func_p0_q;
    logic                    wen_p0_q;
    logic                    ten_p0_q;
    logic [ADDR_W-1:0]       addr_p0_q;
    logic [Z_SIZE-1:0]       sdepth_p0_q;
    logic                    fresh_p0_q;

    logic                    vld_p1_q;
    logic [X_PIXEL_SIZE-1:0] x_p1_q;
    logic [Y_PIXEL_SIZE-1:0] y_p1_q;
    logic [Z_SIZE-1:0]       z_p1_q;
    depth_func_t             func_p1_q;
    logic                    wen_p1_q;
    logic                    ten_p1_q;
    logic [ADDR_W-1:0]       addr_p1_q;
    logic [Z_SIZE-1:0]       sdepth_p1_q;

    logic              hold_p1, adv_p0, accept, pass_p1, fire_p1, wr_tst;
    logic [ADDR_W-1:0] in_addr;
    logic [Z_SIZE-1:0] ram_rdata, sdepth_a, sdepth_a_fwd;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [Z_SIZE-1:0] ram_wdata;

    assign hold_p1      = vld_p1_q && !out_ready_i;
    assign adv_p0       = vld_p0_q && !hold_p1;
    assign frag_ready_o = (state_q == ST_RUN) && (!vld_p0_q || !hold_p1);
    assign accept       = frag_valid_i && frag_ready_o;
    assign in_addr      = pix_addr(frag_x_i, frag_y_i);

    assign pass_p1 = ten_p1_q ? depth_cmp(func_p1_q, z_p1_q, sdepth_p1_q) : 1'b1;
    assign fire_p1 = vld_p1_q && out_ready_i;
    assign wr_tst  = fire_p1 && pass_p1 && wen_p1_q && ten_p1_q;

    // Stage A depth comes from the RAM on its first cycle, from the holding register after.
    assign sdepth_a     = fresh_p0_q ? ram_rdata : sdepth_p0_q;
    assign sdepth_a_fwd = (wr_tst && (addr_p1_q == addr_p0_q)) ? z_p1_q : sdepth_a;

    // Write port is owned by the clear sequencer in CLEAR and by stage B otherwise.
    always_comb begin
        ram_we    = wr_tst;
        ram_waddr = addr_p1_q;
        ram_wdata = z_p1_q;
        if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = cnt_q;
            ram_wdata = CLEAR_VALUE;
        end
    end

    depth_ram #(
        .DATA_W (Z_SIZE),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i     (clk_i),
        .rd_addr_i (in_addr),
        .rd_data_o (ram_rdata),
        .wr_en_i   (ram_we),
        .wr_addr_i (ram_waddr),
        .wr_data_i (ram_wdata)
    );

    // Control state register; reset always restarts a full clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: drain the pipeline, sweep every address, pulse done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN:   if (clear_i) state_d = ST_DRAIN;
            ST_DRAIN: if (!vld_p0_q && !vld_p1_q) state_d = ST_CLEAR;
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end
            end
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_CLEAR;
        endcase
    end

    assign clear_busy_o = (state_q == ST_DRAIN) || (state_q == ST_CLEAR);
    assign clear_done_o = (state_q == ST_DONE);

    // ---- stage A: address registered, RAM read in flight ----
    // Stage A occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p0_q <= 1'b0;
        end else if (accept) begin
            vld_p0_q <= 1'b1;
        end else if (adv_p0) begin
            vld_p0_q <= 1'b0;
        end
    end

    // Stage A payload; a same-cycle write to the address being read overrides the stale RAM data.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            x_p0_q      <= frag_x_i;
            y_p0_q      <= frag_y_i;
            z_p0_q      <= frag_z_i;
            func_p0_q   <= depth_func_i;
            wen_p0_q    <= depth_write_en_i;
            ten_p0_q    <= test_enable_i;
            addr_p0_q   <= in_addr;
            sdepth_p0_q <= z_p1_q;
            fresh_p0_q  <= !(wr_tst && (in_addr == addr_p1_q));
        end else if (vld_p0_q && !adv_p0) begin
            sdepth_p0_q <= sdepth_a_fwd;
            fresh_p0_q  <= 1'b0;
        end
    end

    // ---- stage B: compare, result and write-back ----
    // Stage B occupancy; holds while the result is not taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1_q <= 1'b0;
        end else if (!hold_p1) begin
            vld_p1_q <= vld_p0_q;
        end
    end

    // Stage B payload, loaded only when stage A hands over.
    always_ff @(posedge clk_i) begin
        if (adv_p0) begin
            x_p1_q      <= x_p0_q;
            y_p1_q      <= y_p0_q;
            z_p1_q      <= z_p0_q;
            func_p1_q   <= func_p0_q;
            wen_p1_q    <= wen_p0_q;
            ten_p1_q    <= ten_p0_q;
            addr_p1_q   <= addr_p0_q;
            sdepth_p1_q <= sdepth_a_fwd;
        end
    end

    assign out_valid_o = vld_p1_q;
    assign out_x_o     = x_p1_q;
    assign out_y_o     = y_p1_q;
    assign out_z_o     = z_p1_q;
    assign out_pass_o  = pass_p1;

endmodule

// File: tb/tb_depth_test_unit.sv
// Directed bench for depth_test_unit on a 4x4 buffer with 16-bit depth.
module tb_depth_test_unit;
    import depth_pkg::*;

    localparam int XW = 2;
    localparam int YW = 2;
    localparam int ZW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          frag_valid_i;
    logic          frag_ready_o;
    logic [XW-1:0] frag_x_i;
    logic [YW-1:0] frag_y_i;
    logic [ZW-1:0] frag_z_i;
    depth_func_t   depth_func_i;
    logic          depth_write_en_i;
    logic          test_enable_i;
    logic          clear_i;
    logic          clear_busy_o;
    logic          clear_done_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [XW-1:0] out_x_o;
    logic [YW-1:0] out_y_o;
    logic [ZW-1:0] out_z_o;
    logic          out_pass_o;

    depth_test_unit #(
        .Z_SIZE (ZW),
        .X_RES  (4),
        .Y_RES  (4)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .frag_valid_i     (frag_valid_i),
        .frag_ready_o     (frag_ready_o),
        .frag_x_i         (frag_x_i),
        .frag_y_i         (frag_y_i),
        .frag_z_i         (frag_z_i),
        .depth_func_i     (depth_func_i),
        .depth_write_en_i (depth_write_en_i),
        .test_enable_i    (test_enable_i),
        .clear_i          (clear_i),
        .clear_busy_o     (clear_busy_o),
        .clear_done_o     (clear_done_o),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_x_o          (out_x_o),
        .out_y_o          (out_y_o),
        .out_z_o          (out_z_o),
        .out_pass_o       (out_pass_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [ZW-1:0] z;
        depth_func_t   f;
        logic          we;
        logic          te;
        logic          ex;
    } vec_t;

    vec_t vec[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic add(input logic [XW-1:0] x, input logic [YW-1:0] y, input logic [ZW-1:0] z,
                       input depth_func_t f, input logic we, input logic te, input logic ex);
        vec_t v;
        v.x = x; v.y = y; v.z = z; v.f = f; v.we = we; v.te = te; v.ex = ex;
        vec.push_back(v);
    endtask

    // Waits for a clear to finish: busy for at least 16 cycles, one done pulse, then ready.
    task automatic wait_clear(input string tag);
        int busy_n = 0;
        bit seen   = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_i);
            if (clear_busy_o) busy_n++;
            if (clear_done_o) begin
                seen = 1'b1;
                check_eq({tag, "/ready_in_done"}, frag_ready_o, 1'b0);
            end
        end
        check_eq({tag, "/done_seen"}, seen, 1'b1);
        check_eq({tag, "/busy_ge16"}, (busy_n >= 16), 1'b1);
        @(negedge clk_i);
        check_eq({tag, "/done_one_cycle"}, clear_done_o, 1'b0);
        check_eq({tag, "/busy_low"}, clear_busy_o, 1'b0);
        check_eq({tag, "/ready_after"}, frag_ready_o, 1'b1);
    endtask

    // Streams every queued vector, optionally stalling the output or requesting a clear,
    // and checks each result in order against its hand-computed expectation.
    task automatic run_vec(input string tag, input int stall_at, input int stall_len, input int clear_at);
        int idx = 0;
        int got = 0;
        int cyc = 0;
        int n   = vec.size();
        int acc_cyc[64];
        bit saw_low = 1'b0;
        @(posedge clk_i); #1;
        while ((idx < n || got < n) && cyc < 200) begin
            out_ready_i = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
            clear_i     = (cyc == clear_at);
            if (idx < n) begin
                frag_valid_i     = 1'b1;
                frag_x_i         = vec[idx].x;
                frag_y_i         = vec[idx].y;
                frag_z_i         = vec[idx].z;
                depth_func_i     = vec[idx].f;
                depth_write_en_i = vec[idx].we;
                test_enable_i    = vec[idx].te;
            end else begin
                frag_valid_i = 1'b0;
            end
            @(negedge clk_i);
            if (clear_at >= 0 && cyc == clear_at + 1)
                check_eq({tag, "/busy_rise"}, clear_busy_o, 1'b1);
            if (!out_ready_i && !frag_ready_o) saw_low = 1'b1;
            if (frag_valid_i && frag_ready_o) begin
                acc_cyc[idx] = cyc;
                idx++;
            end
            if (out_valid_o && got < n) begin
                check_eq({tag, "/x"}, out_x_o, vec[got].x);
                check_eq({tag, "/y"}, out_y_o, vec[got].y);
                check_eq({tag, "/z"}, out_z_o, vec[got].z);
                check_eq({tag, "/pass"}, out_pass_o, vec[got].ex);
                if (out_ready_i) begin
                    if (stall_len == 0) check_eq({tag, "/latency"}, cyc - acc_cyc[got], 2);
                    got++;
                end
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        frag_valid_i = 1'b0;
        clear_i      = 1'b0;
        out_ready_i  = 1'b1;
        check_eq({tag, "/in_budget"}, (cyc < 200), 1'b1);
        if (stall_len > 0) check_eq({tag, "/ready_dropped"}, saw_low, 1'b1);
        @(negedge clk_i);
        check_eq({tag, "/no_extra"}, out_valid_o, 1'b0);
        vec.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ZW-1:0] zs  [3];
        logic [2:0]    tab [8];
        zs[0] = 16'h7FFF; zs[1] = 16'h8000; zs[2] = 16'h8001;
        // bit0: z<stored, bit1: z==stored, bit2: z>stored
        tab[0] = 3'b000; tab[1] = 3'b001; tab[2] = 3'b011; tab[3] = 3'b100;
        tab[4] = 3'b110; tab[5] = 3'b010; tab[6] = 3'b101; tab[7] = 3'b111;

        rst_i            = 1'b1;
        frag_valid_i     = 1'b0;
        frag_x_i         = '0;
        frag_y_i         = '0;
        frag_z_i         = '0;
        depth_func_i     = GL_NEVER;
        depth_write_en_i = 1'b0;
        test_enable_i    = 1'b0;
        clear_i          = 1'b0;
        out_ready_i      = 1'b1;

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst/ready", frag_ready_o, 1'b0);
        check_eq("rst/out_valid", out_valid_o, 1'b0);
        check_eq("rst/busy", clear_busy_o, 1'b1);
        check_eq("rst/done", clear_done_o, 1'b0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        wait_clear("rst_clear");

        add(2'd1, 2'd2, 16'h1000, GL_LESS, 1'b0, 1'b1, 1'b1);
        run_vec("first", -1, 0, -1);

        add(2'd1, 2'd2, 16'h1000, GL_LESS, 1'b1, 1'b1, 1'b1);
        add(2'd1, 2'd2, 16'h2000, GL_LESS, 1'b1, 1'b1, 1'b0);
        add(2'd1, 2'd2, 16'h0FFF, GL_LESS, 1'b1, 1'b1, 1'b1);
        run_vec("fwd", -1, 0, -1);

        add(2'd0, 2'd0, 16'h0500, GL_LESS,  1'b0, 1'b1, 1'b1);
        add(2'd0, 2'd0, 16'h0600, GL_LESS,  1'b0, 1'b1, 1'b1);
        add(2'd0, 2'd0, 16'h0100, GL_NEVER, 1'b1, 1'b0, 1'b1);
        add(2'd0, 2'd0, 16'hFFFF, GL_EQUAL, 1'b0, 1'b1, 1'b1);
        run_vec("nowrite", -1, 0, -1);

        add(2'd2, 2'd0, 16'h8000, GL_ALWAYS, 1'b1, 1'b1, 1'b1);
        for (int f = 0; f < 8; f++)
            for (int j = 0; j < 3; j++)
                add(2'd2, 2'd0, zs[j], depth_func_t'(f), 1'b0, 1'b1, tab[f][j]);
        run_vec("sweep", -1, 0, -1);

        add(2'd3, 2'd3, 16'h3000, GL_LESS, 1'b1, 1'b1, 1'b1);
        add(2'd3, 2'd3, 16'h2000, GL_LESS, 1'b1, 1'b1, 1'b1);
        add(2'd3, 2'd3, 16'h2500, GL_LESS, 1'b1, 1'b1, 1'b0);
        run_vec("stall", 2, 5, -1);
        add(2'd3, 2'd3, 16'h2000, GL_EQUAL, 1'b0, 1'b1, 1'b1);
        run_vec("stall_probe", -1, 0, -1);

        add(2'd1, 2'd1, 16'h0100, GL_LESS, 1'b1, 1'b1, 1'b1);
        add(2'd2, 2'd2, 16'h0200, GL_LESS, 1'b1, 1'b1, 1'b1);
        run_vec("clr_inflight", -1, 0, 1);
        wait_clear("clr");

        add(2'd1, 2'd1, 16'h0001, GL_GREATER, 1'b0, 1'b1, 1'b0);
        add(2'd1, 2'd2, 16'h0001, GL_GREATER, 1'b0, 1'b1, 1'b0);
        add(2'd2, 2'd2, 16'h0001, GL_GREATER, 1'b0, 1'b1, 1'b0);
        add(2'd3, 2'd3, 16'hFFFF, GL_EQUAL,   1'b0, 1'b1, 1'b1);
        run_vec("post_clear", -1, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/depth_test_unit.md
Name: depth_test_unit

Overview:
- Parametrised, pipelined successor to the single-fragment depth test.
- Accepts one fragment per cycle over valid/ready and reads the stored depth from an on-chip RAM.
- Applies the per-fragment OpenGL depth function, writes passing depths under a depth-write mask, and emits a pass/fail result to the fragment shader/ROP.
- Supports a sequential full-buffer clear (glClear(GL_DEPTH_BUFFER_BIT)). Sits between the rasteriser and the fragment output stage.

Parameters:
- Z_SIZE, 16, depth width in bits.
- X_RES, 64, horizontal resolution.
- Y_RES, 64, vertical resolution.
- X_PIXEL_SIZE, $clog2(X_RES), x coordinate width.
- Y_PIXEL_SIZE, $clog2(Y_RES), y coordinate width.
- CLEAR_VALUE, {Z_SIZE{1'b1}}, depth written by clear (farthest).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- frag_valid_i  in  1  fragment valid
- frag_ready_o  out  1  fragment accepted when valid&ready
- frag_x_i  in  X_PIXEL_SIZE  pixel x
- frag_y_i  in  Y_PIXEL_SIZE  pixel y
- frag_z_i  in  Z_SIZE  fragment depth
- depth_func_i  in  3  depth_func_t, sampled with fragment
- depth_write_en_i  in  1  glDepthMask, sampled with fragment
- test_enable_i  in  1  GL_DEPTH_TEST, sampled with fragment
- clear_i  in  1  clear request pulse
- clear_busy_o  out  1  clear pending or in progress
- clear_done_o  out  1  one-cycle pulse at clear completion
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream ready
- out_x_o  out  X_PIXEL_SIZE  result x
- out_y_o  out  Y_PIXEL_SIZE  result y
- out_z_o  out  Z_SIZE  fragment depth
- out_pass_o  out  1  depth test passed

Behaviour:
- Memory: X_RES*Y_RES words of Z_SIZE bits; address = y*X_RES + x. Synchronous read; on read/write collision the read returns old data. Contents are not reset.
- Reset: state=CLEAR with counter=0. Outputs: frag_ready_o=0, out_valid_o=0, clear_busy_o=1, clear_done_o=0. Reset therefore always initialises the buffer. Reset asserted mid-operation discards all in-flight fragments and restarts the clear.
- FSM states: RUN, DRAIN, CLEAR, DONE.
  - RUN: clear_i=1 -> DRAIN. clear_busy_o rises the next cycle.
  - DRAIN: frag_ready_o=0; when both stages are empty -> CLEAR.
  - CLEAR: writes CLEAR_VALUE at counter, counter+1 per cycle; after address X_RES*Y_RES-1 -> DONE.
  - DONE: clear_done_o=1 for one cycle, clear_busy_o=0 -> RUN.
  - clear_i outside RUN is ignored.
- Pipeline has two stages.
  - A: address registered and RAM read.
  - B: compare and result.
  - A fragment accepted in cycle N presents out_valid_o in cycle N+2. Throughput is 1/cycle while out_ready_i=1.
- Stall: B holds while out_valid_o&&!out_ready_i; A holds while B holds. frag_ready_o = (state==RUN) && (A empty || A advances); the combinational path from out_ready_i is permitted.
- Stage A depth: RAM data in the cycle after entry, then held in a register while stalled.
- Compare in B (unsigned, fragment vs stored):
  - NEVER=0: never passes.
  - LESS=1: <.
  - LEQUAL=2: <=.
  - GREATER=3: >.
  - GEQUAL=4: >=.
  - EQUAL=5: ==.
  - NOTEQUAL=6: !=.
  - ALWAYS=7: always passes.
  - test_enable=0: pass=1 and no write.
- Write: exactly once, in the cycle the B result handshakes (out_valid_o&&out_ready_i), iff pass && depth_write_en && test_enable.
- Forwarding: if a B write targets the same address as the fragment in A (including the cycle A's read is issued or held), A's stored depth is replaced by the written z. Back-to-back same-pixel fragments must therefore see the latest depth.
- out_* are held stable while out_valid_o=1 and out_ready_i=0.

Decomposition:
- Package depth_pkg: depth_func_t (3-bit enum GL_NEVER..GL_ALWAYS), dtu_state_t (RUN, DRAIN, CLEAR, DONE).
- Sub-module depth_ram: simple dual-port RAM with one sync read port and one write port, old-data-on-collision. Clear and the test stage share its write port, muxed by state.

Test Plan:
All scenarios use X_RES=4, Y_RES=4, Z_SIZE=16.
- After reset: clear_busy_o=1 for 16+ cycles, clear_done_o pulses once, then frag_ready_o=1. Fragment (1,2) z=0x1000 LESS -> pass=1 at accept+2.
- Fragments (1,2) z=0x1000 then (1,2) z=0x2000 back-to-back, LESS, write_en=1 -> pass=1 then pass=0 (forwarding). A third fragment z=0x0FFF -> pass=1.
- Fragment (0,0) z=0x0500 with write_en=0, then z=0x0600 LESS -> both pass (no write). Repeat with test_enable=0 and func=NEVER -> pass=1, stored depth still 0xFFFF.
- Sweep all 8 functions with stored 0x8000 and z in {0x7FFF, 0x8000, 0x8001} -> pass vectors match the compare table above.
- Hold out_ready_i=0 for 5 cycles with 3 fragments streaming -> out_* stable, frag_ready_o drops, no loss or duplication, each write done once.
- clear_i while 2 fragments are in flight -> both results delivered first, then 16 clear cycles and clear_done_o. A following GREATER z=0x0001 at any pixel -> pass=0.
